seg7_mmio_ctrl: RTL and testbench

//  Memory-mapped N-digit seven-segment display controller; successor to the fixed 8-digit hex display.

---
 rtl/seg7_mmio_ctrl_pkg.sv | 42 ++++
 rtl/seg7_mmio_ctrl_if.sv | 11 +
 rtl/seg7_hex_decode.sv | 9 +
 rtl/seg7_mmio_ctrl.sv | 145 ++++++++++++++
 tb/tb_seg7_mmio_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_mmio_ctrl_pkg.sv
// Shared definitions for the memory-mapped seven-segment controller:
// register offsets, CTRL field positions and the hex-to-segment table.
package seg7_mmio_ctrl_pkg;

  typedef enum logic [1:0] {
    REG_DATA   = 2'd0,
    REG_CTRL   = 2'd1,
    REG_RAW_LO = 2'd2,
    REG_RAW_HI = 2'd3
  } reg_addr_e;

  localparam int CTRL_RAW_BIT   = 0;
  localparam int CTRL_SUP_BIT   = 1;
  localparam int CTRL_EN_LSB    = 8;
  localparam int CTRL_BLINK_LSB = 16;
  localparam int CTRL_DP_LSB    = 24;

  // Active-low segment pattern, bit order g..a.
  function automatic logic [6:0] hex7(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_mmio_ctrl_if.sv
// CPU-side register bus of the seven-segment controller.
interface seg7_mmio_ctrl_if;
  logic        cs;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output cs, we, addr, wdata, input rdata);
  modport slave  (input cs, we, addr, wdata, output rdata);
endinterface

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low seven-segment pattern (g..a).
module seg7_hex_decode
  import seg7_mmio_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = hex7(nibble);
endmodule

// File: rtl/seg7_mmio_ctrl.sv
// Memory-mapped N-digit multiplexed seven-segment display controller with
// raw mode, leading-zero suppression, decimal points, enable/blink masks.
module seg7_mmio_ctrl
  import seg7_mmio_ctrl_pkg::*;
#(
  parameter int DIGITS       = 8,
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic              clk,
  input  logic              reset,
  seg7_mmio_ctrl_if.slave   bus,
  output logic [7:0]        o_seg,
  output logic [DIGITS-1:0] o_sel
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [4*DIGITS-1:0]   data_r;
  logic                  raw_mode;
  logic                  suppress;
  logic [DIGITS-1:0]     en_mask;
  logic [DIGITS-1:0]     blink_mask;
  logic [DIGITS-1:0]     dp_mask;
  logic [DIGITS-1:0][7:0] raw_pat;

  logic [CNT_W-1:0] scan_cnt;
  logic [IDX_W-1:0] idx;
  logic [FR_W-1:0]  frame_cnt;
  logic             phase;

  // CTRL bits 2..7 are reserved and never stored.
  logic unused_wdata;
  assign unused_wdata = ^bus.wdata[7:2];

  // Register file: bus writes; every field has a defined reset value.
  // NOTE: these are a handful of flops rather than a RAM, so they can and must take the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      data_r     <= '0;
      raw_mode   <= 1'b0;
      suppress   <= 1'b0;
      en_mask    <= '1;
      blink_mask <= '0;
      dp_mask    <= '0;
      raw_pat    <= '1;
    end else if (bus.cs && bus.we) begin
      case (reg_addr_e'(bus.addr))
        REG_DATA: data_r <= bus.wdata[4*DIGITS-1:0];
        REG_CTRL: begin
          raw_mode   <= bus.wdata[CTRL_RAW_BIT];
          suppress   <= bus.wdata[CTRL_SUP_BIT];
          en_mask    <= bus.wdata[CTRL_EN_LSB +: DIGITS];
          blink_mask <= bus.wdata[CTRL_BLINK_LSB +: DIGITS];
          dp_mask    <= bus.wdata[CTRL_DP_LSB +: DIGITS];
        end
        REG_RAW_LO: for (int i = 0; i < DIGITS && i < 4; i++) raw_pat[i] <= bus.wdata[8*i +: 8];
        REG_RAW_HI: for (int i = 4; i < DIGITS; i++) raw_pat[i] <= bus.wdata[8*(i-4) +: 8];
        default: ;
      endcase
    end
  end

  // Read-back mux; fields for absent digits read as zero.
  always_comb begin
    logic [7:0]  en8, bl8, dp8;
    logic [63:0] raw_all;
    // NOTE: every comb output gets a default first so no path can infer a latch.
    bus.rdata = '0;
    en8 = '0;
    bl8 = '0;
    dp8 = '0;
    raw_all = '0;
    en8[DIGITS-1:0] = en_mask;
    bl8[DIGITS-1:0] = blink_mask;
    dp8[DIGITS-1:0] = dp_mask;
    raw_all[8*DIGITS-1:0] = raw_pat;
    if (bus.cs && !bus.we) begin
      case (reg_addr_e'(bus.addr))
        REG_DATA:   bus.rdata[4*DIGITS-1:0] = data_r;
        REG_CTRL:   bus.rdata = {dp8, bl8, en8, 6'b0, suppress, raw_mode};
        REG_RAW_LO: bus.rdata = raw_all[31:0];
        default:    bus.rdata = raw_all[63:32];
      endcase
    end
  end

  // Scan counter, digit index, frame counter and blink phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      phase     <= 1'b0;
    end else if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
      scan_cnt <= '0;
      if (idx == IDX_W'(DIGITS - 1)) begin
        idx <= '0;
        if (frame_cnt == FR_W'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          phase     <= ~phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end else begin
        idx <= idx + 1'b1;
      end
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [3:0]          nibble;
  logic [6:0]          hex_seg;
  logic [4*DIGITS-1:0] upper;
  logic                blank;
  logic [7:0]          seg_next;

  seg7_hex_decode u_dec (.nibble(nibble), .seg(hex_seg));

  // Pick the current digit and decide whether it is blanked.
  always_comb begin
    nibble   = data_r[{idx, 2'b00} +: 4];
    upper    = data_r >> {idx, 2'b00};
    blank    = !en_mask[idx]
            || (blink_mask[idx] && phase)
            || (!raw_mode && suppress && (idx != '0) && (upper == '0));
    seg_next = raw_mode ? raw_pat[idx] : {~dp_mask[idx], hex_seg};
  end

  // Registered pin drivers, refreshed every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_sel <= '1;
      o_seg <= 8'hFF;
    end else begin
      o_sel <= blank ? '1 : ~(DIGITS'(1) << idx);
      o_seg <= blank ? 8'hFF : seg_next;
    end
  end

endmodule

// File: tb/tb_seg7_mmio_ctrl.sv
// Self-checking bench for seg7_mmio_ctrl: randomized and directed register
// traffic checked against a cycle-position reference model.
module tb_seg7_mmio_ctrl;
  import seg7_mmio_ctrl_pkg::*;

  localparam int DIGITS       = 8;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [7:0]        o_seg;
  logic [DIGITS-1:0] o_sel;

  seg7_mmio_ctrl_if bus ();

  seg7_mmio_ctrl #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .o_seg(o_seg), .o_sel(o_sel)
  );

  always #5 clk = ~clk;

  // Clock edges seen since reset release.
  int unsigned cyc;
  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Reference register image.
  logic [31:0] m_data, m_ctrl, m_raw_lo, m_raw_hi;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  function automatic void model_reset();
    m_data = 32'h0; m_ctrl = 32'h0000FF00; m_raw_lo = 32'hFFFFFFFF; m_raw_hi = 32'hFFFFFFFF;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0: return m_data;
      2'd1: return m_ctrl;
      2'd2: return m_raw_lo;
      default: return m_raw_hi;
    endcase
  endfunction

  // Expected pins after the edge that closes cycle position p.
  function automatic void model_expect(input int unsigned p, output logic [7:0] sel, output logic [7:0] seg);
    int unsigned i, frames, ph;
    logic [63:0] raw64;
    logic [31:0] hi;
    logic blank;
    i      = (p / SCAN_DIV) % DIGITS;
    frames = p / (SCAN_DIV * DIGITS);
    ph     = (frames / BLINK_FRAMES) % 2;
    hi     = m_data >> (4 * i);
    blank  = !m_ctrl[8 + i] || (m_ctrl[16 + i] && ph == 1)
          || (!m_ctrl[0] && m_ctrl[1] && i > 0 && hi == 0);
    raw64  = {m_raw_hi, m_raw_lo};
    if (blank) begin
      sel = 8'hFF;
      seg = 8'hFF;
    end else begin
      sel = 8'hFF;
      sel[i] = 1'b0;
      if (m_ctrl[0]) seg = raw64[8*i +: 8];
      else           seg = {~m_ctrl[24 + i], hex_tab[hi[3:0]][6:0]};
    end
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    #1;
    tests++;
    if (bus.rdata !== 32'h0) begin
      fails++;
      $display("FAIL rdata_during_write: got %h, expected 00000000", bus.rdata);
    end
    @(posedge clk);
    #1;
    bus.cs = 1'b0; bus.we = 1'b0;
    case (a)
      2'd0: m_data   = d;
      2'd1: m_ctrl   = d & 32'hFFFFFF03;
      2'd2: m_raw_lo = d;
      default: m_raw_hi = d;
    endcase
  endtask

  task automatic bus_read_check(input logic [1:0] a, input string name);
    logic [31:0] exp;
    @(negedge clk);
    bus.cs = 1'b1; bus.we = 1'b0; bus.addr = a;
    #1;
    exp = model_read(a);
    tests++;
    if (bus.rdata !== exp) begin
      fails++;
      $display("FAIL %s: rdata=%h, expected %h", name, bus.rdata, exp);
    end
    bus.cs = 1'b0;
    #1;
    tests++;
    if (bus.rdata !== 32'h0) begin
      fails++;
      $display("FAIL %s_idle: rdata=%h with cs low, expected 00000000", name, bus.rdata);
    end
  endtask

  task automatic check_scan(input int n, input string name);
    logic [7:0] es, eg;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      model_expect(cyc - 1, es, eg);
      tests++;
      if (o_sel !== es || o_seg !== eg) begin
        fails++;
        $display("FAIL %s cyc=%0d: o_sel=%h o_seg=%h, expected o_sel=%h o_seg=%h",
                 name, cyc, o_sel, o_seg, es, eg);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (o_sel !== 8'hFF || o_seg !== 8'hFF) begin
      fails++;
      $display("FAIL reset_pins: o_sel=%h o_seg=%h, expected FF FF", o_sel, o_seg);
    end
    reset = 1'b1;
    check_scan(6, "first_digit");
    bus_read_check(REG_CTRL, "reset_ctrl");
    bus_read_check(REG_RAW_LO, "reset_raw_lo");
    bus_read_check(REG_RAW_HI, "reset_raw_hi");
    bus_read_check(REG_DATA, "reset_data");
  endtask

  task automatic test_hex();
    bus_write(REG_DATA, 32'h12345678);
    check_scan(40, "hex_scan");
    bus_read_check(REG_DATA, "hex_data_rb");
  endtask

  task automatic test_suppress();
    bus_write(REG_DATA, 32'h00000A05);
    bus_write(REG_CTRL, 32'h0000FF02);
    check_scan(64, "suppress_scan");
    bus_read_check(REG_CTRL, "suppress_ctrl_rb");
  endtask

  task automatic test_raw();
    bus_write(REG_CTRL, 32'h0100FF01);
    bus_write(REG_RAW_LO, 32'h00000055);
    check_scan(64, "raw_scan");
  endtask

  task automatic test_blink();
    bus_write(REG_DATA, 32'h12345678);
    bus_write(REG_CTRL, 32'h0001FF00);
    check_scan(160, "blink_scan");
  endtask

  task automatic test_back_to_back();
    bus_write(REG_DATA, $urandom);
    bus_write(REG_CTRL, $urandom | 32'h0000FF00);
    bus_write(REG_RAW_LO, $urandom);
    bus_write(REG_RAW_HI, $urandom);
    bus_read_check(REG_DATA, "b2b_data");
    bus_read_check(REG_CTRL, "b2b_ctrl");
    bus_read_check(REG_RAW_LO, "b2b_raw_lo");
    bus_read_check(REG_RAW_HI, "b2b_raw_hi");
    check_scan(40, "b2b_scan");
  endtask

  task automatic test_random();
    logic [1:0]  a;
    logic [31:0] d;
    for (int it = 0; it < 30; it++) begin
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == REG_DATA && $urandom_range(0, 1) == 1) d = d & 32'h000FF00F;
      if ($urandom_range(0, 3) != 0) bus_write(a, d);
      else bus_read_check(a, "rand_read");
      check_scan($urandom_range(1, 12), "rand_scan");
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    bus_write(REG_DATA, 32'h12345678);
    bus_write(REG_CTRL, 32'h0000FF00);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(posedge clk);
      #1;
      if (o_sel === 8'hDF) found = 1'b1;
    end
    tests++;
    if (!found) begin
      fails++;
      $display("FAIL reset_mid_wait: digit5 never driven within 100 cycles, o_sel=%h", o_sel);
    end
    #2;
    reset = 1'b0;
    #1;
    tests++;
    if (o_sel !== 8'hFF || o_seg !== 8'hFF) begin
      fails++;
      $display("FAIL reset_mid_blank: o_sel=%h o_seg=%h, expected FF FF", o_sel, o_seg);
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    check_scan(10, "reset_mid_restart");
    bus_read_check(REG_CTRL, "reset_mid_ctrl");
    bus_read_check(REG_DATA, "reset_mid_data");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cs = 1'b0; bus.we = 1'b0; bus.addr = 2'd0; bus.wdata = 32'h0;
    test_reset();
    test_hex();
    test_suppress();
    test_raw();
    test_blink();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
